riscv_gpio: RTL and testbench

RISCV_GPIO -- requirements
Module: riscv_gpio

---
 rtl/riscv_gpio_if.sv | 37 +++
 rtl/riscv_gpio.sv | 139 +++++++++++++
 tb/tb_riscv_gpio.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_gpio_if.sv
// ============================================================================
// riscv_gpio_if : memory-mapped bus between CPU address decode and GPIO block
// Revision 1.0
// ============================================================================
`default_nettype none

interface riscv_gpio_if;
  logic        i_Sel;
  logic [3:0]  i_Addr;
  logic [31:0] i_WData;
  logic [3:0]  i_WMask;
  logic        i_RStrobe;
  logic [31:0] o_RData;
  logic        o_RValid;

  modport master (
    output i_Sel,
    output i_Addr,
    output i_WData,
    output i_WMask,
    output i_RStrobe,
    input  o_RData,
    input  o_RValid
  );

  modport slave (
    input  i_Sel,
    input  i_Addr,
    input  i_WData,
    input  i_WMask,
    input  i_RStrobe,
    output o_RData,
    output o_RValid
  );
endinterface

`default_nettype wire

// File: rtl/riscv_gpio.sv
// ============================================================================
// riscv_gpio : LED/IRQ registers plus synchronized, debounced switches
// Revision 1.0
// ============================================================================
`default_nettype none

module riscv_gpio #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic [3:0]  LED_RESET       = 4'b0000
) (
  input  logic        i_Clk,
  input  logic        i_ResetN,
  riscv_gpio_if.slave bus,
  input  logic [3:0]  i_Switch,
  output logic [3:0]  o_LED,
  output logic        o_IRQ
);

  localparam int unsigned        C_CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] C_REG_LED    = 2'd0;
  localparam logic [1:0] C_REG_SWITCH = 2'd1;
  localparam logic [1:0] C_REG_EDGE   = 2'd2;
  localparam logic [1:0] C_REG_IRQ_EN = 2'd3;

  logic [3:0]  r_sync1;
  logic [3:0]  r_sync2;
  logic [3:0]  w_deb;
  logic [3:0]  w_rise;

  logic [3:0]  r_led;
  logic [3:0]  r_edge;
  logic [3:0]  r_irq_en;
  logic [31:0] r_rdata;
  logic        r_rvalid;

  logic        w_wr;
  logic        w_rd;
  logic [1:0]  w_reg_sel;
  logic [3:0]  w_edge_clr;
  logic [31:0] w_rd_mux;
  logic        w_unused_bus;

  assign w_wr      = bus.i_Sel & bus.i_WMask[0];
  assign w_rd      = bus.i_Sel & bus.i_RStrobe;
  assign w_reg_sel = bus.i_Addr[3:2];

  assign w_unused_bus = ^{bus.i_WData[31:4], bus.i_WMask[3:1], bus.i_Addr[1:0]};

  always_ff @(posedge i_Clk) begin
    if (!i_ResetN) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
    end else begin
      r_sync1 <= i_Switch;
      r_sync2 <= r_sync1;
    end
  end

  // The counter only runs while the synchronized input disagrees with the
  // accepted state; any agreement restarts the stability window.
  for (genvar g = 0; g < 4; g++) begin : g_debounce
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_deb;
    logic               w_differs;
    logic               w_expire;

    assign w_differs = r_sync2[g] ^ r_deb;
    assign w_expire  = w_differs & (r_cnt == C_CNT_MAX);

    always_ff @(posedge i_Clk) begin
      if (!i_ResetN) begin
        r_cnt <= '0;
        r_deb <= 1'b0;
      end else if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_expire) begin
        r_deb <= r_sync2[g];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + C_CNT_W'(1);
      end
    end

    assign w_deb[g]  = r_deb;
    assign w_rise[g] = w_expire & r_sync2[g];
  end

  always_comb begin
    w_edge_clr = 4'b0000;
    if (w_wr && (w_reg_sel == C_REG_EDGE)) begin
      w_edge_clr = bus.i_WData[3:0];
    end
  end

  always_comb begin
    w_rd_mux = 32'd0;
    case (w_reg_sel)
      C_REG_LED:    w_rd_mux[3:0] = r_led;
      C_REG_SWITCH: w_rd_mux[3:0] = w_deb;
      C_REG_EDGE:   w_rd_mux[3:0] = r_edge;
      C_REG_IRQ_EN: w_rd_mux[3:0] = r_irq_en;
      default:      w_rd_mux      = 32'd0;
    endcase
  end

  // Read data is captured from pre-edge register values, so a read and a
  // write to the same register in one cycle returns the old contents.
  always_ff @(posedge i_Clk) begin
    if (!i_ResetN) begin
      r_led    <= LED_RESET;
      r_irq_en <= 4'b0000;
      r_edge   <= 4'b0000;
      r_rdata  <= 32'd0;
      r_rvalid <= 1'b0;
    end else begin
      if (w_wr && (w_reg_sel == C_REG_LED)) begin
        r_led <= bus.i_WData[3:0];
      end
      if (w_wr && (w_reg_sel == C_REG_IRQ_EN)) begin
        r_irq_en <= bus.i_WData[3:0];
      end
      r_edge   <= (r_edge & ~w_edge_clr) | w_rise;
      r_rvalid <= w_rd;
      if (w_rd) begin
        r_rdata <= w_rd_mux;
      end
    end
  end

  assign bus.o_RData  = r_rdata;
  assign bus.o_RValid = r_rvalid;
  assign o_LED        = r_led;
  assign o_IRQ        = |(r_edge & r_irq_en);

endmodule

`default_nettype wire

// File: tb/tb_riscv_gpio.sv
// ============================================================================
// tb_riscv_gpio : directed stimulus with a cycle model of the GPIO block
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_riscv_gpio;

  localparam int         D      = 16;
  localparam logic [3:0] LED_RV = 4'b0011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = 4'b0000;
  logic [3:0] led;
  logic       irq;

  int checks = 0;
  int errors = 0;

  riscv_gpio_if bus ();

  riscv_gpio #(
    .DEBOUNCE_CYCLES (D),
    .LED_RESET       (LED_RV)
  ) dut (
    .i_Clk    (clk),
    .i_ResetN (rst_n),
    .bus      (bus),
    .i_Switch (sw),
    .o_LED    (led),
    .o_IRQ    (irq)
  );

  always #5 clk = ~clk;

  // Reference model: debounced bit flips once the last D synchronized
  // samples (switch value from two edges earlier) all oppose it.
  logic [3:0]  m_led, m_irq_en, m_edge, m_deb, m_nd, m_rise, m_clr;
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic        model_ok = 1'b0;
  logic [3:0]  hist[$];

  function automatic bit window_flip(input int b, input logic want);
    int n;
    logic [3:0] v;
    n = hist.size();
    if (n < D + 1) return 1'b0;
    for (int j = 0; j < D; j++) begin
      v = hist[n-2-j];
      if (v[b] !== want) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [3:0] model_reg(input logic [1:0] sel);
    case (sel)
      2'd0:    return m_led;
      2'd1:    return m_deb;
      2'd2:    return m_edge;
      default: return m_irq_en;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_led = LED_RV; m_irq_en = 4'h0; m_edge = 4'h0; m_deb = 4'h0;
      m_rdata = 32'd0; m_rvalid = 1'b0;
      hist.delete();
      model_ok = 1'b1;
    end else begin
      m_rvalid = bus.i_Sel && bus.i_RStrobe;
      if (m_rvalid) m_rdata = {28'd0, model_reg(bus.i_Addr[3:2])};
      m_nd = m_deb;
      for (int b = 0; b < 4; b++)
        if (window_flip(b, ~m_deb[b])) m_nd[b] = ~m_deb[b];
      m_rise = m_nd & ~m_deb;
      m_clr = 4'h0;
      if (bus.i_Sel && bus.i_WMask[0]) begin
        case (bus.i_Addr[3:2])
          2'd0:    m_led = bus.i_WData[3:0];
          2'd2:    m_clr = bus.i_WData[3:0];
          2'd3:    m_irq_en = bus.i_WData[3:0];
          default: ;
        endcase
      end
      m_edge = (m_edge & ~m_clr) | m_rise;
      m_deb = m_nd;
      hist.push_back(sw);
      if (hist.size() > D + 4) void'(hist.pop_front());
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      check("cyc_led",    32'(led),          32'(m_led));
      check("cyc_irq",    32'(irq),          32'(|(m_edge & m_irq_en)));
      check("cyc_rvalid", 32'(bus.o_RValid), 32'(m_rvalid));
      check("cyc_rdata",  bus.o_RData,       m_rdata);
    end
  end

  task automatic idle();
    bus.i_Sel = 1'b0; bus.i_Addr = 4'h0; bus.i_WData = 32'd0;
    bus.i_WMask = 4'h0; bus.i_RStrobe = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    bus.i_Sel = 1'b1; bus.i_Addr = a; bus.i_WData = d; bus.i_WMask = m; bus.i_RStrobe = 1'b0;
    cycles(1);
    idle();
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] a, input logic [31:0] exp);
    bus.i_Sel = 1'b1; bus.i_Addr = a; bus.i_RStrobe = 1'b1; bus.i_WMask = 4'h0;
    cycles(1);
    idle();
    check({nm, "_valid"}, 32'(bus.o_RValid), 32'd1);
    check(nm, bus.o_RData, exp);
  endtask

  // Back-to-back reads; the value set at edge 'flip' is visible from read k=flip+1.
  task automatic stream(input string nm, input logic [3:0] a, input int n, input int flip,
                        input logic [31:0] mask, input logic [31:0] val);
    bus.i_Sel = 1'b1; bus.i_Addr = a; bus.i_RStrobe = 1'b1; bus.i_WMask = 4'h0;
    for (int k = 1; k <= n; k++) begin
      cycles(1);
      check(nm, bus.o_RData & mask, (k > flip) ? val : 32'd0);
    end
    idle();
  endtask

  initial begin
    idle();
    // Bus activity during reset must be ignored.
    bus.i_Sel = 1'b1; bus.i_RStrobe = 1'b1; bus.i_WMask = 4'h1; bus.i_WData = 32'hC;
    cycles(3);
    check("rst_led",    32'(led),          32'h3);
    check("rst_irq",    32'(irq),          32'h0);
    check("rst_rvalid", 32'(bus.o_RValid), 32'h0);
    check("rst_rdata",  bus.o_RData,       32'h0);
    idle();
    rst_n = 1'b1;
    cycles(2);

    wr(4'h0, 32'h5, 4'b0001);
    check("led_wr5", 32'(led), 32'h5);
    rd_chk("rd_led5", 4'h0, 32'h5);
    wr(4'h0, 32'hF, 4'b0010);
    check("led_mask", 32'(led), 32'h5);
    wr(4'h4, 32'hF, 4'b0001);
    rd_chk("rd_sw_ro", 4'h4, 32'h0);

    sw[0] = 1'b1; cycles(10); sw[0] = 1'b0;
    cycles(30);
    rd_chk("glitch_sw",   4'h4, 32'h0);
    rd_chk("glitch_edge", 4'h8, 32'h0);

    sw[0] = 1'b1;
    stream("step_sw0", 4'h4, 20, 18, 32'h1, 32'h1);
    cycles(20);
    rd_chk("step_edge", 4'h8, 32'h1);

    wr(4'hC, 32'h1, 4'b0001);
    check("irq_on", 32'(irq), 32'h1);
    wr(4'h8, 32'h1, 4'b0001);
    check("irq_w1c", 32'(irq), 32'h0);
    rd_chk("edge_clr", 4'h8, 32'h0);
    wr(4'hC, 32'h0, 4'b0001);
    sw[1] = 1'b1; cycles(D + 4);
    rd_chk("edge_b1", 4'h8, 32'h2);
    check("irq_masked", 32'(irq), 32'h0);
    wr(4'hC, 32'h2, 4'b0001);
    check("irq_b1", 32'(irq), 32'h1);
    wr(4'h8, 32'h2, 4'b0001);
    check("irq_b1_clr", 32'(irq), 32'h0);

    sw[2] = 1'b1; cycles(17);
    wr(4'h8, 32'h4, 4'b0001);
    rd_chk("set_wins", 4'h8, 32'h4);
    wr(4'h8, 32'h4, 4'b0001);
    rd_chk("edge_b2_clr", 4'h8, 32'h0);

    sw[1] = 1'b0; cycles(D + 4);
    rd_chk("fall_edge", 4'h8, 32'h0);
    rd_chk("fall_sw",   4'h4, 32'h5);

    bus.i_Sel = 1'b1; bus.i_RStrobe = 1'b1; bus.i_WMask = 4'h1;
    bus.i_Addr = 4'h0; bus.i_WData = 32'h9;
    cycles(1);
    idle();
    check("rw_old", bus.o_RData, 32'h5);
    check("rw_led", 32'(led),    32'h9);

    sw[1] = 1'b1; cycles(D + 4);
    wr(4'h0, 32'hA, 4'b0001);
    check("led_a", 32'(led), 32'hA);
    check("irq_pre_rst", 32'(irq), 32'h1);
    sw[3] = 1'b1; cycles(8);
    rst_n = 1'b0;
    cycles(1);
    check("mid_rst_led", 32'(led), 32'h3);
    check("mid_rst_irq", 32'(irq), 32'h0);
    check("mid_rst_rdata", bus.o_RData, 32'h0);
    rst_n = 1'b1;
    stream("rel_edge", 4'h8, 20, 18, 32'hF, 32'hF);
    rd_chk("rel_led",   4'h0, 32'h3);
    rd_chk("rel_irqen", 4'hC, 32'h0);
    rd_chk("rel_sw",    4'h4, 32'hF);
    cycles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
